// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store controller with lane extraction, sign/zero extension and RMW sub-word stores.
// Optional one-entry word buffer when MAU_WORD_BUF_EN is defined.
module mem_access_unit #(
  parameter int unsigned READ_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  output logic        cpu_ready,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_funct3,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, din_q, din_d, rdata_q, rdata_d;
  logic [15:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d, err_q, err_d;
  logic        illegal, hit;
  logic [31:0] buf_word;

  function automatic logic [31:0] lane_ext(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f);
    logic [31:0] s;
    s = w >> {a, 3'b000};
    return (f[1:0] == 2'b10) ? w
         : f[0] ? (f[2] ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]})
         : (f[2] ? {24'b0, s[7:0]} : {{24{s[7]}}, s[7:0]});
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f,
                                        input logic [15:0] d);
    return f[0] ? (a[1] ? {d, w[15:0]} : {w[31:16], d})
         : ((w & ~(32'h0000_00FF << {a, 3'b000})) | ({24'b0, d[7:0]} << {a, 3'b000}));
  endfunction

  assign illegal = (cpu_funct3 == 3'b011) || (cpu_funct3[2:1] == 2'b11) || (cpu_we && cpu_funct3[2])
                || (cpu_funct3[1:0] == 2'b01 && cpu_addr[0])
                || (cpu_funct3 == 3'b010 && cpu_addr[1:0] != 2'b00);

`ifdef MAU_WORD_BUF_EN
  logic        buf_v_q;
  logic [29:0] buf_a_q;
  logic [31:0] buf_d_q;
  assign hit      = buf_v_q && (buf_a_q == cpu_addr[31:2]);
  assign buf_word = buf_d_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_v_q <= 1'b0;
      buf_a_q <= '0;
      buf_d_q <= '0;
    end else if (state_q == RD && cnt_q == 4'd0) begin
      buf_v_q <= 1'b1;
      buf_a_q <= addr_q[31:2];
      buf_d_q <= mem_dout;
    end else if (state_q == WR) begin
      buf_v_q <= 1'b1;
      buf_a_q <= addr_q[31:2];
      buf_d_q <= din_q;
    end
  end
`else
  assign hit      = 1'b0;
  assign buf_word = '0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    we_d    = we_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (cpu_req) begin
        addr_d  = cpu_addr;
        wdata_d = cpu_wdata[15:0];
        f3_d    = cpu_funct3;
        we_d    = cpu_we;
        err_d   = illegal;
        cnt_d   = 4'(READ_WAIT);
        if (illegal) state_d = RESP;
        else if (cpu_we && cpu_funct3 == 3'b010) begin
          state_d = WR;
          din_d   = cpu_wdata;
        end else if (hit && cpu_we) begin
          state_d = WR;
          din_d   = merge(buf_word, cpu_addr[1:0], cpu_funct3, cpu_wdata[15:0]);
        end else if (hit) begin
          state_d = RESP;
          rdata_d = lane_ext(buf_word, cpu_addr[1:0], cpu_funct3);
        end else state_d = RD;
      end
      RD: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
          else if (we_q) begin
            state_d = WR;
            din_d   = merge(mem_dout, addr_q[1:0], f3_q, wdata_q);
          end else begin
            state_d = RESP;
            rdata_d = lane_ext(mem_dout, addr_q[1:0], f3_q);
          end
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      din_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory-side outputs are decoded from state so reset silences them immediately.
  assign cpu_ready = state_q == IDLE;
  assign mem_read  = state_q == RD;
  assign mem_write = state_q == WR;
  assign mem_addr  = (mem_read || mem_write) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_din   = mem_write ? din_q : 32'h0;
  assign cpu_done  = state_q == RESP;
  assign cpu_err   = cpu_done && err_q;
  assign cpu_rdata = rdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized bench for mem_access_unit (READ_WAIT 0 and 3) against a transaction-level model.
module tb_mem_access_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic req[2], we[2], ready[2], done[2], err[2], mrd[2], mwr[2];
  logic [2:0]  f3[2];
  logic [31:0] addr[2], wdata[2], rdata[2], maddr[2], mdin[2], dout[2];
  logic [31:0] ram[2][256];
  logic        poke = 1'b0;
  int          pk_d;
  logic [7:0]  pk_i;
  logic [31:0] pk_v;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_access_unit #(.READ_WAIT(g * 3)) dut (
      .clk(clk), .reset(reset), .cpu_req(req[g]), .cpu_ready(ready[g]), .cpu_we(we[g]),
      .cpu_funct3(f3[g]), .cpu_addr(addr[g]), .cpu_wdata(wdata[g]), .cpu_done(done[g]),
      .cpu_err(err[g]), .cpu_rdata(rdata[g]), .mem_addr(maddr[g]), .mem_din(mdin[g]),
      .mem_read(mrd[g]), .mem_write(mwr[g]), .mem_dout(dout[g]));
    assign dout[g] = ram[g][maddr[g][9:2]];
  end

  always @(posedge clk) begin
    if (poke) ram[pk_d][pk_i] <= pk_v;
    for (int i = 0; i < 2; i++) if (mwr[i]) ram[i][maddr[i][9:2]] <= mdin[i];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state and the expected timeline of the current transaction.
  logic [31:0] ref_mem[2][256];
  logic [31:0] ref_rdata[2];
  logic        buf_v[2];
  logic [29:0] buf_a[2];
  logic [31:0] buf_d[2];
  int          act = -1, acc_cyc = 0, n_done = 0, rd_lo = 1, rd_hi = 0, wr_t = 0;
  logic        e_err;
  logic [31:0] e_maddr, e_din, p_rdata;
  logic        chk_en = 1'b0;
  int          ncmp = 0, nbad = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    ncmp++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f);
    longint v;
    int sh;
    sh = 8 * int'(a[1:0]);
    if (f == 3'b010) return w;
    if (f[0]) begin
      v = longint'((w >> sh) & 32'hFFFF);
      if (!f[2] && v >= 32768) v -= 65536;
    end else begin
      v = longint'((w >> sh) & 32'hFF);
      if (!f[2] && v >= 128) v -= 256;
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f,
                                          input logic [31:0] wd);
    logic [7:0] by[4];
    for (int i = 0; i < 4; i++) by[i] = w[8*i +: 8];
    if (f[0]) begin
      by[2*int'(a[1])]     = wd[7:0];
      by[2*int'(a[1]) + 1] = wd[15:8];
    end else by[int'(a[1:0])] = wd[7:0];
    return {by[3], by[2], by[1], by[0]};
  endfunction

  always @(negedge clk) begin
    int t;
    logic erd, ewr, edn;
    if (chk_en) for (int d = 0; d < 2; d++) begin
      t   = (d == act) ? cyc - acc_cyc : 1000;
      erd = t >= rd_lo && t <= rd_hi;
      ewr = t == wr_t;
      edn = t == n_done;
      chk($sformatf("ready%0d t=%0d", d, t), 32'(ready[d]), 32'(t > n_done));
      chk($sformatf("mem_read%0d t=%0d", d, t), 32'(mrd[d]), 32'(erd));
      chk($sformatf("mem_write%0d t=%0d", d, t), 32'(mwr[d]), 32'(ewr));
      chk($sformatf("done%0d t=%0d", d, t), 32'(done[d]), 32'(edn));
      chk($sformatf("mem_addr%0d t=%0d", d, t), maddr[d], (erd || ewr) ? e_maddr : 32'h0);
      chk($sformatf("rdata%0d t=%0d", d, t), rdata[d], (d == act && t < n_done) ? p_rdata : ref_rdata[d]);
      if (edn) chk($sformatf("err%0d", d), 32'(err[d]), 32'(e_err));
      if (ewr) chk($sformatf("mem_din%0d", d), mdin[d], e_din);
      else if (!erd) chk($sformatf("mem_din_idle%0d t=%0d", d, t), mdin[d], 32'h0);
    end
  end

  task automatic do_poke(input int d, input int i, input logic [31:0] v);
    pk_d = d; pk_i = 8'(i); pk_v = v; poke = 1'b1;
    ref_mem[d][i] = v;
    @(posedge clk);
    #1 poke = 1'b0;
  endtask

  task automatic wait_ready(input int d);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready[d]) return;
    end
    ncmp++; nbad++;
    $display("FAIL ready_timeout dut%0d: got 0 expected 1", d);
  endtask

  task automatic txn(input int d, input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
    logic ill, hit;
    int idx, rw;
    logic [31:0] word;
    wait_ready(d);
    #2;
    idx = int'(a[9:2]);
    rw  = d * 3;
    ill = f == 3'd3 || f == 3'd6 || f == 3'd7 || (w && f[2]) ||
          (f[1:0] == 2'b01 && a[0]) || (f == 3'd2 && a[1:0] != 2'b00);
`ifdef MAU_WORD_BUF_EN
    hit = buf_v[d] && buf_a[d] == a[31:2];
`else
    hit = 1'b0;
`endif
    e_maddr = {a[31:2], 2'b00};
    p_rdata = ref_rdata[d];
    e_err = ill; rd_lo = 1; rd_hi = 0; wr_t = 0; e_din = 32'h0;
    if (ill) n_done = 1;
    else if (w && f == 3'd2) begin
      wr_t = 1; n_done = 2; e_din = wd;
    end else begin
      word = hit ? buf_d[d] : ref_mem[d][idx];
      if (!hit) rd_hi = rw + 1;
      if (!w) begin
        n_done = hit ? 1 : rw + 2;
        ref_rdata[d] = m_load(word, a, f);
      end else begin
        wr_t = hit ? 1 : rw + 2;
        n_done = wr_t + 1;
        e_din = m_merge(word, a, f, wd);
      end
      buf_v[d] = 1'b1; buf_a[d] = a[31:2]; buf_d[d] = word;
    end
    if (wr_t != 0) begin
      ref_mem[d][idx] = e_din;
      buf_v[d] = 1'b1; buf_a[d] = a[31:2]; buf_d[d] = e_din;
    end
    act = d; acc_cyc = cyc;
    req[d] = 1'b1; we[d] = w; f3[d] = f; addr[d] = a; wdata[d] = wd;
    @(posedge clk);
    #1 req[d] = 1'b0;
    we[d] = 1'($urandom); f3[d] = 3'($urandom); addr[d] = $urandom; wdata[d] = $urandom;
    repeat (n_done) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; f3[d] = 3'd0; addr[d] = 32'h0; wdata[d] = 32'h0;
      ref_rdata[d] = 32'h0; buf_v[d] = 1'b0; buf_a[d] = '0; buf_d[d] = 32'h0;
    end
    #3;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 32'(ready[d]), 32'd1);
      chk("rst_done", 32'({done[d], err[d], mrd[d], mwr[d]}), 32'd0);
      chk("rst_maddr", maddr[d], 32'h0);
      chk("rst_mdin", mdin[d], 32'h0);
      chk("rst_rdata", rdata[d], 32'h0);
    end
    for (int d = 0; d < 2; d++) for (int i = 0; i < 256; i++) do_poke(d, i, $urandom);
    do_poke(0, 64, 32'h8899AABB);
    do_poke(1, 128, 32'hDEADBEEF);
    @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;

    txn(0, 1'b0, 3'd0, 32'h101, 32'h0);
    chk("lb_latency", 32'(n_done), 32'd2);
    chk("lb_rdata", rdata[0], 32'hFFFFFFAA);
    txn(0, 1'b0, 3'd5, 32'h102, 32'h0);
    chk("lhu_rdata", rdata[0], 32'h00008899);
    txn(0, 1'b0, 3'd1, 32'h102, 32'h0);
    chk("lh_rdata", rdata[0], 32'hFFFF8899);
    txn(0, 1'b0, 3'd2, 32'h100, 32'h0);
    chk("lw_rdata", rdata[0], 32'h8899AABB);
    txn(0, 1'b1, 3'd0, 32'h103, 32'h12345677);
    chk("sb_mem", ram[0][64], 32'h7799AABB);
    chk("sb_rdata_kept", rdata[0], 32'h8899AABB);
    txn(1, 1'b0, 3'd2, 32'h200, 32'h0);
    chk("lw_rw3_latency", 32'(n_done), 32'd5);
    chk("lw_rw3_rdata", rdata[1], 32'hDEADBEEF);
    txn(0, 1'b0, 3'd2, 32'h102, 32'h0);
    chk("err_lw_latency", 32'(n_done), 32'd1);
    txn(0, 1'b1, 3'd1, 32'h001, 32'h5555);
    txn(0, 1'b0, 3'd3, 32'h100, 32'h0);
    chk("err_rdata_kept", rdata[0], 32'h8899AABB);
    chk("err_mem_kept", ram[0][0], ref_mem[0][0]);
`ifdef MAU_WORD_BUF_EN
    txn(0, 1'b0, 3'd2, 32'h300, 32'h0);
    txn(0, 1'b0, 3'd2, 32'h300, 32'h0);
    chk("buf_hit_latency", 32'(n_done), 32'd1);
`endif

    // Reset in the middle of an SW write cycle.
    wait_ready(0);
    #2;
    chk_en = 1'b0; act = -1;
    req[0] = 1'b1; we[0] = 1'b1; f3[0] = 3'd2; addr[0] = 32'h40; wdata[0] = 32'hCAFEF00D;
    @(posedge clk);
    #1 req[0] = 1'b0;
    chk("sw_write_active", 32'(mwr[0]), 32'd1);
    reset = 1'b0;
    #1 chk("rst_write_drop", 32'(mwr[0]), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ref_rdata[d] = 32'h0; buf_v[d] = 1'b0;
    end
    chk("rst_mem_kept", ram[0][16], ref_mem[0][16]);
    chk("rst_ready_after", 32'(ready[0]), 32'd1);
    @(negedge clk);
    chk_en = 1'b1;

    for (int d = 0; d < 2; d++) for (int k = 0; k < 60; k++) begin
      int i;
      i = ($urandom_range(0, 3) == 0) ? 64 : $urandom_range(0, 255);
      txn(d, 1'($urandom), 3'($urandom), {22'b0, 8'(i), 2'($urandom)}, $urandom);
    end
    for (int d = 0; d < 2; d++) for (int i = 0; i < 256; i += 17) chk("final_mem", ram[d][i], ref_mem[d][i]);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store controller between the CPU datapath and the word-addressed data memory.
- The data memory reads asynchronously (mem_read, dout), writes synchronously (mem_write, din), and uses 32-bit words (addr >> 2).
- This block accepts one CPU load/store at a time and performs byte-lane extraction and sign/zero extension.
- Sub-word stores are done as read-modify-write. Misaligned and illegal accesses are rejected without touching memory.

Parameters:
- READ_WAIT, 0, extra cycles mem_read is held before mem_dout is sampled (0..15); models slower memory.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- cpu_req  input  1  request valid
- cpu_ready  output  1  unit idle; request accepted at an edge where cpu_req && cpu_ready
- cpu_we  input  1  1 = store, 0 = load
- cpu_funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- cpu_addr  input  32  byte address
- cpu_wdata  input  32  store data; low byte/half used for B/H
- cpu_done  output  1  one-cycle completion pulse
- cpu_err  output  1  valid with cpu_done; access rejected
- cpu_rdata  output  32  load result, extended to 32 bits
- mem_addr  output  32  byte address to data memory; bits [1:0] always 0
- mem_din  output  32  word to write
- mem_read  output  1  read strobe
- mem_write  output  1  write strobe; memory writes at the next rising edge
- mem_dout  input  32  asynchronous read data from memory

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - cpu_done, cpu_err, mem_read, mem_write, mem_addr, mem_din and cpu_rdata all 0.
  - An in-flight write is dropped: mem_write falls before the next edge.
- Outputs:
  - cpu_ready = (state == IDLE).
  - cpu_addr, cpu_we, cpu_funct3 and cpu_wdata are latched at the accept edge. Inputs are ignored outside IDLE.
  - mem_read is 1 only in RD. mem_write is 1 only in WR.
  - mem_addr/mem_din are held stable for the whole RD/WR state and are 0 in IDLE/RESP.
- Error check at accept:
  - funct3 in {011, 110, 111} is illegal.
  - A store with funct3 100 or 101 is illegal.
  - Misaligned: H/HU with addr[0] = 1; W with addr[1:0] != 0.
  - Error path: IDLE -> RESP with cpu_err = 1. No mem_read or mem_write is issued and cpu_rdata is unchanged.
- FSM states: IDLE, RD, WR, RESP.
  - IDLE -> RD: load, or B/H store.
  - IDLE -> WR: SW.
  - RD lasts READ_WAIT+1 cycles, counted by a 4-bit down-counter. mem_dout is sampled on the final RD cycle's edge.
  - RD -> RESP (load) or RD -> WR (sub-word store).
  - WR lasts 1 cycle, then -> RESP.
  - RESP lasts 1 cycle with cpu_done = 1, then -> IDLE. A new request may be accepted on the edge leaving IDLE the next cycle.
- Latency: cpu_done is high N cycles after the accept edge.
  - Load: N = READ_WAIT+2.
  - SW: N = 2.
  - SB/SH: N = READ_WAIT+3.
  - Error: N = 1.
- Lane rules, little-endian:
  - Byte lane = addr[1:0]. Half lane = addr[1].
  - B/H loads sign-extend; BU/HU loads zero-extend.
  - Merge replaces only the addressed lane(s) of the sampled word with cpu_wdata[7:0] or cpu_wdata[15:0].
- cpu_rdata is updated on load completion and holds until the next successful load. Stores do not change it.

Optional Feature:
- Macro: MAU_WORD_BUF_EN. When defined, a one-entry word buffer (valid, word address, data) is compiled in.
  - The buffer is filled by every RD sample and every WR.
  - Reset and error responses do not fill it; reset clears valid.
  - Load hitting the buffer (valid and addr[31:2] equal): IDLE -> RESP with no mem_read; N = 1.
  - SB/SH hitting the buffer: merge from buffer, IDLE -> WR; N = 2.
- Undefined: no buffer, and every load and sub-word store goes through RD.

Test Plan:
- READ_WAIT=0, mem word 0x100 = 0x8899AABB, LB addr 0x101 -> mem_read one cycle with mem_addr = 0x100; cpu_done 2 cycles after accept; cpu_rdata = 0xFFFFFFAA, cpu_err = 0.
- Same word, LHU addr 0x102 -> cpu_rdata = 0x00008899; LH -> 0xFFFF8899; LW 0x100 -> 0x8899AABB.
- SB addr 0x103 wdata 0x12345677 -> RD then WR with mem_din = 0x7799AABB; cpu_done at accept+3; mem_write high exactly 1 cycle.
- READ_WAIT=3, LW 0x200 holding 0xDEADBEEF -> mem_read high 4 consecutive cycles; cpu_done at accept+5; cpu_rdata = 0xDEADBEEF.
- LW addr 0x102, SH addr 0x001, funct3 = 011 -> each gives cpu_done + cpu_err at accept+1, no mem_read/mem_write, cpu_rdata unchanged.
- Assert reset low during WR of an SW -> mem_write drops immediately, target word unchanged, cpu_ready = 1 after release. With MAU_WORD_BUF_EN: LW 0x100 twice -> second completes at accept+1 with no mem_read.
